mod_arbiter: RTL
================

// Module: mod_arbiter
// PURPOSE
//   Shares one constant-divisor modulo datapath (mod_comb) between N_REQ requesters in the PUCCH chain
//   (e.g. hopping-index, cyclic-shift and sequence-index calculators). Round-robin arbitration, valid/ready
//   handshakes on every requester and on the single result port, 2-stage registered pipeline, 1 result/cycle.
// PARAMETERS
//   N_REQ           4              number of requesters, 2..8
//   DIVIDER         12             constant divisor passed to mod_comb (12, 24, 30 or 192)
//   ONE_DIV_DIVIDER mod_pkg lookup 34-bit reciprocal of DIVIDER for mod_comb; default = mod_pkg::one_div(DIVIDER)
//   ID_W            $clog2(N_REQ)  requester-id width
// PORTS
//   i_clk           in   1          clock
//   i_rst           in   1          synchronous reset, active-high
//   i_req_valid     in   N_REQ      request valid per requester
//   i_req_dividend  in   16*N_REQ   dividend; requester n at [16n+:16]
//   o_req_ready     out  N_REQ      one-hot (or zero) accept; a transfer occurs when valid & ready
//   o_rsp_valid     out  1          result valid
//   o_rsp_result    out  16         dividend mod DIVIDER
//   o_rsp_id        out  ID_W       index of the requester that issued this result
//   i_rsp_ready     in   1          downstream accepts result
// BEHAVIOUR
//   - Reset (i_rst=1 at an i_clk edge): o_rsp_valid=0, o_rsp_result=0, o_rsp_id=0, S1 empty, rr pointer=0.
//     o_req_ready is 0 while i_rst is high. In-flight data is dropped; no result is emitted for it.
//   - Pipeline: S1 = {valid, dividend, id}, registered at accept. mod_comb is combinational from S1.dividend.
//     S2 = output registers {o_rsp_valid, o_rsp_result, o_rsp_id}. Latency: accept at edge k -> o_rsp_valid
//     high after edge k+1 (2 edges, 1 full cycle in S1).
//   - adv2 = ~o_rsp_valid | i_rsp_ready; S2 loads S1 when adv2. o_rsp_valid <= S1.valid when adv2; else holds.
//   - adv1 = ~S1.valid | adv2; S1 accepts a new grant when adv1; otherwise holds (stall propagates back).
//   - Output stable rule: while o_rsp_valid & ~i_rsp_ready, o_rsp_result/o_rsp_id do not change.
//   - Arbitration (combinational, registered pointer): search i_req_valid from index rr_ptr upward with
//     wrap-around to N_REQ-1 -> 0; first hit g is granted. o_req_ready[g]=adv1 & ~i_rst; all others 0.
//     On transfer rr_ptr <= (g==N_REQ-1) ? 0 : g+1; no transfer -> rr_ptr holds.
//   - No valid requests: o_req_ready=0, S1.valid <= 0 if adv1.
//   - o_req_ready depends on i_req_valid of other requesters (combinational); requesters must not make
//     i_req_valid depend on o_req_ready. Once asserted, i_req_valid/dividend hold until transfer.
//   - Full throughput: with i_rsp_ready held 1 and all requesters valid, one grant per cycle, order 0,1,2,..
//   - Arithmetic: result width 16, exact mod for all 16-bit dividends (0..65535) given correct ONE_DIV_DIVIDER.
// CONFIGURATION
//   MOD_ARB_STATS_EN defined: extra port o_grant_cnt out 16*N_REQ; per-requester count of transfers,
//     saturating at 16'hFFFF, cleared by i_rst. Not defined: port and counters absent; datapath identical.
// STRUCTURE
//   - mod_pkg: DATA_W=16, RECIP_W=34, localparams ONE_DIV_12=34'h2AAAAAAAA, ONE_DIV_24=34'h155555555,
//     ONE_DIV_30=34'h111111111, ONE_DIV_192=34'h02AAAAAAB, function one_div(int d) returning these (0 else).
//   - One sub-module: mod_comb (existing), single instance between S1 and S2. Arbiter kept inline.
// TESTING
//   1 Reset: hold i_rst 3 cycles with all valid=1 -> o_req_ready=0, o_rsp_valid=0, no transfers.
//   2 Single req, DIVIDER=12: req1 dividend 100 -> o_rsp_valid 2 edges later, result 4, id 1.
//   3 Round-robin, N_REQ=4, all valid, dividends 0x0010*(n+1), i_rsp_ready=1 -> ids 0,1,2,3,0.. one per cycle;
//     results (DIVIDER=12) 4,8,0,4.
//   4 Backpressure: DIVIDER=192, req0 65535 then req2 1000, i_rsp_ready=0 for 5 cycles -> o_rsp_result
//     holds 63 id 0; o_req_ready=0 once S1 full; release -> 63 then 40, none lost or duplicated.
//   5 Reset mid-operation: assert i_rst with S1 and S2 full -> next edge o_rsp_valid=0, rr_ptr=0, no stale output.
//   6 Exhaustive/random per DIVIDER in {12,24,30,192}: 65536 dividends across random requesters and random
//     i_rsp_ready -> every result equals dividend % DIVIDER, id matches issuer; with MOD_ARB_STATS_EN the
//     counters equal per-requester transfer counts.

Source files
------------

// File: rtl/mod_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mod_pkg                                                                  |
// | Shared widths and 34-bit reciprocal constants for the modulo datapath.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package mod_pkg;

  localparam int DATA_W  = 16;
  localparam int RECIP_W = 34;

  // Reciprocals are scaled by 2^37; mod_comb takes the quotient from product bits [49:37].
  localparam logic [RECIP_W-1:0] ONE_DIV_12  = 34'h2AAAAAAAA;
  localparam logic [RECIP_W-1:0] ONE_DIV_24  = 34'h155555555;
  localparam logic [RECIP_W-1:0] ONE_DIV_30  = 34'h111111111;
  localparam logic [RECIP_W-1:0] ONE_DIV_192 = 34'h02AAAAAAB;

  function automatic logic [RECIP_W-1:0] one_div(input int d);
    case (d)
      12:      one_div = ONE_DIV_12;
      24:      one_div = ONE_DIV_24;
      30:      one_div = ONE_DIV_30;
      192:     one_div = ONE_DIV_192;
      default: one_div = '0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mod_comb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mod_comb                                                                 |
// | Combinational dividend mod DIVIDER via reciprocal multiply and one       |
// | corrective subtract.                                                     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mod_comb
  import mod_pkg::*;
#(
  parameter int                 DIVIDER         = 12,
  parameter logic [RECIP_W-1:0] ONE_DIV_DIVIDER = one_div(DIVIDER)
) (
  input  logic [DATA_W-1:0] i_dividend,
  output logic [DATA_W-1:0] o_result
);

  localparam int c_PROD_W = DATA_W + RECIP_W;
  localparam int c_SHIFT  = 37;
  localparam int c_REM_W  = DATA_W + 8;

  logic [c_PROD_W-1:0] w_prod;
  logic [DATA_W-1:0]   w_quot;
  logic [c_REM_W-1:0]  w_qd;
  logic [c_REM_W-1:0]  w_rem;

  assign w_prod = c_PROD_W'(i_dividend) * c_PROD_W'(ONE_DIV_DIVIDER);
  assign w_quot = DATA_W'(w_prod >> c_SHIFT);
  assign w_qd   = c_REM_W'(w_quot) * c_REM_W'(DIVIDER);
  assign w_rem  = c_REM_W'(i_dividend) - w_qd;

  // A truncated reciprocal can leave the quotient one short on exact multiples.
  assign o_result = (w_rem >= c_REM_W'(DIVIDER)) ? DATA_W'(w_rem - c_REM_W'(DIVIDER))
                                                  : DATA_W'(w_rem);

endmodule
`default_nettype wire

// File: rtl/mod_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mod_arbiter                                                              |
// | Round-robin sharing of one mod_comb between N_REQ requesters, 2-stage    |
// | valid/ready pipeline. MOD_ARB_STATS_EN adds per-requester grant counters.|
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module mod_arbiter
  import mod_pkg::*;
#(
  parameter int                 N_REQ           = 4,
  parameter int                 DIVIDER         = 12,
  parameter logic [RECIP_W-1:0] ONE_DIV_DIVIDER = one_div(DIVIDER),
  parameter int                 ID_W            = $clog2(N_REQ)
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [DATA_W*N_REQ-1:0]   i_req_dividend,
  output logic [N_REQ-1:0]          o_req_ready,
`ifdef MOD_ARB_STATS_EN
  output logic [DATA_W*N_REQ-1:0]   o_grant_cnt,
`endif
  output logic                      o_rsp_valid,
  output logic [DATA_W-1:0]         o_rsp_result,
  output logic [ID_W-1:0]           o_rsp_id,
  input  logic                      i_rsp_ready
);

  logic              r_s1_valid;
  logic [DATA_W-1:0] r_s1_dividend;
  logic [ID_W-1:0]   r_s1_id;
  logic [ID_W-1:0]   r_rr_ptr;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_result;
  logic [ID_W-1:0]   r_rsp_id;

  logic              w_adv1;
  logic              w_adv2;
  logic              w_found;
  logic              w_xfer;
  logic [ID_W-1:0]   w_grant_id;
  logic [DATA_W-1:0] w_grant_div;
  logic [DATA_W-1:0] w_mod_result;

  assign w_adv2 = ~r_rsp_valid | i_rsp_ready;
  assign w_adv1 = ~r_s1_valid | w_adv2;
  assign w_xfer = w_found & w_adv1 & ~i_rst;

  // First valid requester at or after the pointer, wrapping past N_REQ-1.
  always_comb begin
    int idx;
    w_found     = 1'b0;
    w_grant_id  = '0;
    w_grant_div = '0;
    idx         = 0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = (int'(r_rr_ptr) + i) % N_REQ;
      if (!w_found && i_req_valid[idx]) begin
        w_found     = 1'b1;
        w_grant_id  = ID_W'(idx);
        w_grant_div = i_req_dividend[idx*DATA_W +: DATA_W];
      end
    end
  end

  assign o_req_ready = w_xfer ? (N_REQ'(1) << w_grant_id) : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rr_ptr <= '0;
    end else if (w_xfer) begin
      r_rr_ptr <= (w_grant_id == ID_W'(N_REQ - 1)) ? '0 : w_grant_id + ID_W'(1);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_s1_valid    <= 1'b0;
      r_s1_dividend <= '0;
      r_s1_id       <= '0;
    end else if (w_adv1) begin
      r_s1_valid    <= w_xfer;
      r_s1_dividend <= w_grant_div;
      r_s1_id       <= w_grant_id;
    end
  end

  mod_comb #(
    .DIVIDER         (DIVIDER),
    .ONE_DIV_DIVIDER (ONE_DIV_DIVIDER)
  ) u_mod_comb (
    .i_dividend (r_s1_dividend),
    .o_result   (w_mod_result)
  );

  // Holding on ~w_adv2 keeps the result stable while downstream stalls.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_id     <= '0;
    end else if (w_adv2) begin
      r_rsp_valid  <= r_s1_valid;
      r_rsp_result <= w_mod_result;
      r_rsp_id     <= r_s1_id;
    end
  end

  assign o_rsp_valid  = r_rsp_valid;
  assign o_rsp_result = r_rsp_result;
  assign o_rsp_id     = r_rsp_id;

`ifdef MOD_ARB_STATS_EN
  for (genvar n = 0; n < N_REQ; n++) begin : g_stats
    logic [DATA_W-1:0] r_cnt;
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        r_cnt <= '0;
      end else if (w_xfer && (w_grant_id == ID_W'(n)) && (r_cnt != {DATA_W{1'b1}})) begin
        r_cnt <= r_cnt + DATA_W'(1);
      end
    end
    assign o_grant_cnt[n*DATA_W +: DATA_W] = r_cnt;
  end
`endif

endmodule
`default_nettype wire
